// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Register busy-bit scoreboard with RAW/WAW stall, writeback bypass,
//            deadlock and spurious-writeback detection. Optional stall
//            statistics counter enabled by macro HAZARD_SCOREBOARD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = 8,
   parameter int STALL_MAX = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   issue_valid,
   input  logic                   issue_regwrite,
   input  logic [ADDR_W-1:0]      issue_rd,
   input  logic [ADDR_W-1:0]      issue_rs1,
   input  logic [ADDR_W-1:0]      issue_rs2,
   input  logic                   wb_valid,
   input  logic [ADDR_W-1:0]      wb_rd,
   input  logic [DATA_W-1:0]      wb_data,
   output logic                   stall,
   output logic                   fwd_rs1,
   output logic                   fwd_rs2,
   output logic [DATA_W-1:0]      fwd_data,
   output logic [(1<<ADDR_W)-1:0] pending,
   output logic                   deadlock,
   output logic                   wb_err,
   output logic [15:0]            stall_count
);

   localparam int NREG  = 1 << ADDR_W;
   localparam int CNT_W = $clog2(STALL_MAX + 1);

   logic             hit_rs1, hit_rs2, hit_rd;
   logic             haz_rs1, haz_rs2, haz_waw;
   logic             accept;
   logic [NREG-1:0]  set_vec, clr_vec;
   logic [CNT_W-1:0] stall_run, stall_run_next;

   // A writeback landing this cycle resolves the hazard it would otherwise cause.
   always_comb begin
      hit_rs1  = wb_valid && (wb_rd == issue_rs1);
      hit_rs2  = wb_valid && (wb_rd == issue_rs2);
      hit_rd   = wb_valid && (wb_rd == issue_rd);
      haz_rs1  = pending[issue_rs1] && !hit_rs1;
      haz_rs2  = pending[issue_rs2] && !hit_rs2;
      haz_waw  = issue_regwrite && pending[issue_rd] && !hit_rd;
      stall    = !reset && issue_valid && (haz_rs1 || haz_rs2 || haz_waw);
      fwd_rs1  = !reset && issue_valid && hit_rs1;
      fwd_rs2  = !reset && issue_valid && hit_rs2;
      fwd_data = wb_data;
      accept   = issue_valid && !stall;
      set_vec  = (accept && issue_regwrite) ? (NREG'(1) << issue_rd) : '0;
      clr_vec  = wb_valid ? (NREG'(1) << wb_rd) : '0;
      if (!stall)
         stall_run_next = '0;
      else if (stall_run == CNT_W'(STALL_MAX))
         stall_run_next = stall_run;
      else
         stall_run_next = stall_run + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending   <= '0;
         stall_run <= '0;
         deadlock  <= 1'b0;
         wb_err    <= 1'b0;
      end else begin
         pending   <= (pending & ~clr_vec) | set_vec;
         stall_run <= stall_run_next;
         if (stall && (stall_run_next == CNT_W'(STALL_MAX)))
            deadlock <= 1'b1;
         if (wb_valid && !pending[wb_rd])
            wb_err <= 1'b1;
      end
   end

`ifdef HAZARD_SCOREBOARD_STATS_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_count <= '0;
      else if (stall && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end
`else
   assign stall_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed table-driven bench for hazard_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

`ifdef HAZARD_SCOREBOARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, issue_valid, issue_regwrite, wb_valid;
   logic [2:0] issue_rd, issue_rs1, issue_rs2, wb_rd;
   logic [7:0] wb_data;
   logic       stall, fwd_rs1, fwd_rs2, deadlock, wb_err;
   logic [7:0] fwd_data, pending;
   logic [15:0] stall_count;

   int checks = 0;
   int errors = 0;

   hazard_scoreboard #(.ADDR_W(3), .DATA_W(8), .STALL_MAX(15)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
      .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_data(fwd_data),
      .pending(pending), .deadlock(deadlock), .wb_err(wb_err),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, iv, irw;
      logic [2:0] ird, rs1, rs2;
      logic       wv;
      logic [2:0] wrd;
      logic [7:0] wd;
      logic       st, f1, f2;
      logic [7:0] pend;
      logic       err, dl;
      logic [15:0] sc;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic rst, input logic iv, input logic irw,
                        input logic [2:0] ird, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic wv, input logic [2:0] wrd, input logic [7:0] wd);
      @(negedge clk);
      reset = rst; issue_valid = iv; issue_regwrite = irw;
      issue_rd = ird; issue_rs1 = rs1; issue_rs2 = rs2;
      wb_valid = wv; wb_rd = wrd; wb_data = wd;
      #1;
   endtask

   function automatic logic [15:0] exp_sc(input logic [15:0] v);
      return STATS ? v : 16'd0;
   endfunction

   initial begin
      //          rst iv irw ird rs1 rs2 wv wrd wd     st f1 f2 pend   err dl sc
      tbl[0]  = '{1, 1, 1, 3, 2, 2, 1, 2, 8'h11,  0, 0, 0, 8'h00, 0, 0, 0};
      tbl[1]  = '{0, 1, 1, 3, 0, 1, 0, 0, 8'h00,  0, 0, 0, 8'h00, 0, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 3, 0, 0, 0, 8'h00,  1, 0, 0, 8'h08, 0, 0, 0};
      tbl[3]  = '{0, 1, 0, 0, 3, 0, 1, 3, 8'hA5,  0, 1, 0, 8'h08, 0, 0, 1};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00, 0, 0, 1};
      tbl[5]  = '{0, 1, 1, 5, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00, 0, 0, 1};
      tbl[6]  = '{0, 1, 1, 5, 1, 2, 1, 5, 8'h3C,  0, 0, 0, 8'h20, 0, 0, 1};
      tbl[7]  = '{0, 0, 1, 1, 5, 5, 0, 0, 8'h00,  0, 0, 0, 8'h20, 0, 0, 1};
      tbl[8]  = '{0, 0, 0, 0, 5, 5, 1, 5, 8'h77,  0, 0, 0, 8'h20, 0, 0, 1};
      tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 6, 8'h00,  0, 0, 0, 8'h00, 0, 0, 1};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00, 1, 0, 1};
      tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00, 1, 0, 1};
      tbl[12] = '{0, 1, 1, 2, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00, 1, 0, 1};
      tbl[13] = '{0, 1, 1, 2, 0, 0, 0, 0, 8'h00,  1, 0, 0, 8'h04, 1, 0, 1};
      tbl[14] = '{0, 1, 0, 0, 4, 2, 1, 2, 8'h99,  0, 0, 1, 8'h04, 1, 0, 2};
      tbl[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00, 1, 0, 2};
      tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00, 0, 0, 0};

      drive(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].rst, tbl[i].iv, tbl[i].irw, tbl[i].ird, tbl[i].rs1, tbl[i].rs2,
               tbl[i].wv, tbl[i].wrd, tbl[i].wd);
         chk($sformatf("v%0d stall", i),       stall,       tbl[i].st);
         chk($sformatf("v%0d fwd_rs1", i),     fwd_rs1,     tbl[i].f1);
         chk($sformatf("v%0d fwd_rs2", i),     fwd_rs2,     tbl[i].f2);
         chk($sformatf("v%0d fwd_data", i),    fwd_data,    tbl[i].wd);
         chk($sformatf("v%0d pending", i),     pending,     tbl[i].pend);
         chk($sformatf("v%0d wb_err", i),      wb_err,      tbl[i].err);
         chk($sformatf("v%0d deadlock", i),    deadlock,    tbl[i].dl);
         chk($sformatf("v%0d stall_count", i), stall_count, exp_sc(tbl[i].sc));
      end

      // Sustained rs2 hazard: deadlock appears on the 15th stalled edge.
      drive(0, 1, 1, 4, 0, 0, 0, 0, 8'h00);
      chk("dl issue stall", stall, 1'b0);
      for (int k = 0; k < 18; k++) begin
         drive(0, 1, 0, 0, 0, 4, 0, 0, 8'h00);
         chk($sformatf("dl k%0d stall", k), stall, 1'b1);
         chk($sformatf("dl k%0d deadlock", k), deadlock, (k >= 15) ? 1'b1 : 1'b0);
         chk($sformatf("dl k%0d stall_count", k), stall_count, exp_sc(16'(k)));
      end

      // Fill every busy bit, then reset with a concurrent hazardous issue.
      for (int r = 0; r < 8; r++) begin
         if (r != 4) begin
            drive(0, 1, 1, 3'(r), 3'(r), 3'(r), 0, 0, 8'h00);
            chk($sformatf("fill r%0d stall", r), stall, 1'b0);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      chk("full pending", pending, 8'hFF);
      chk("full deadlock", deadlock, 1'b1);
      drive(1, 1, 1, 4, 4, 4, 1, 4, 8'h5A);
      chk("rst stall", stall, 1'b0);
      chk("rst fwd_rs1", fwd_rs1, 1'b0);
      chk("rst fwd_rs2", fwd_rs2, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      chk("post-rst pending", pending, 8'h00);
      chk("post-rst deadlock", deadlock, 1'b0);
      chk("post-rst stall_count", stall_count, 16'h0000);
      chk("post-rst wb_err", wb_err, 1'b0);

      // An in-flight write discarded by reset becomes a spurious writeback.
      drive(0, 1, 1, 1, 0, 0, 0, 0, 8'h00);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      chk("inflight pending", pending, 8'h02);
      drive(0, 0, 0, 0, 0, 0, 1, 1, 8'h42);
      chk("inflight cleared", pending, 8'h00);
      chk("inflight err before", wb_err, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      chk("inflight err after", wb_err, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register index width (2^ADDR_W tracked registers).
REQ-002 SHALL have parameter DATA_W, default 8, writeback data width.
REQ-003 SHALL have parameter STALL_MAX, default 15, number of consecutive stall cycles that flags deadlock.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports issue_valid (in, 1), issue_regwrite (in, 1), issue_rd / issue_rs1 / issue_rs2 (in, ADDR_W): instruction at decode requesting issue.
REQ-007 SHALL have ports wb_valid (in, 1), wb_rd (in, ADDR_W), wb_data (in, DATA_W): a producer completing a register write.
REQ-008 SHALL have output stall (1): decode must hold its instruction.
REQ-009 SHALL have outputs fwd_rs1, fwd_rs2 (1 each) and fwd_data (DATA_W): same-cycle bypass of wb_data to the issuing instruction.
REQ-010 SHALL have outputs pending (2^ADDR_W): registered busy vector; deadlock (1) and wb_err (1): sticky error flags; stall_count (16): stall statistics.

Function
REQ-011 SHALL treat an issue as accepted in a cycle when issue_valid=1 and stall=0.
REQ-012 SHALL set pending[issue_rd] on the next edge for an accepted issue with issue_regwrite=1.
REQ-013 SHALL clear pending[wb_rd] on the next edge when wb_valid=1.
REQ-014 SHALL keep pending[r]=1 when the same edge both sets and clears r (set wins).
REQ-015 SHALL treat register 0 like any other register (no hardwired zero).
REQ-016 SHALL define src hazard on rs1 as pending[issue_rs1]=1 and not (wb_valid=1 and wb_rd=issue_rs1); rs2 likewise.
REQ-017 SHALL define a WAW hazard as issue_regwrite=1, pending[issue_rd]=1 and not (wb_valid=1 and wb_rd=issue_rd).
REQ-018 SHALL drive stall combinationally = issue_valid and (rs1 hazard or rs2 hazard or WAW hazard).
REQ-019 SHALL drive fwd_rs1 = issue_valid and wb_valid and (wb_rd=issue_rs1); fwd_rs2 likewise; fwd_data = wb_data; all zero-latency combinational.
REQ-020 SHALL assert fwd_rsN even when pending[issue_rsN]=0, so a writeback is never missed by a same-cycle reader.
REQ-021 SHALL count consecutive stall=1 cycles in a saturating counter, cleared on any cycle with stall=0.
REQ-022 SHALL set deadlock on the edge where that counter reaches STALL_MAX; deadlock stays set until reset and does not block stall generation.
REQ-023 SHALL set wb_err on the edge after wb_valid=1 with pending[wb_rd]=0 (spurious writeback), and still apply REQ-013; sticky until reset.
REQ-024 SHALL ignore issue_rd, issue_rs1, issue_rs2 and issue_regwrite when issue_valid=0.

Reset
REQ-025 SHALL, on an edge with reset=1, clear pending, the stall counter, stall_count, deadlock and wb_err, overriding any same-cycle issue or writeback.
REQ-026 SHALL force stall, fwd_rs1 and fwd_rs2 to 0 combinationally while reset=1.
REQ-027 SHALL discard in-flight writes on reset mid-operation; a later wb_valid to a cleared register raises wb_err per REQ-023.

Configuration
REQ-028 SHALL, with macro HAZARD_SCOREBOARD_STATS_EN defined, increment stall_count once per cycle with stall=1, saturating at 16'hFFFF.
REQ-029 SHALL, without HAZARD_SCOREBOARD_STATS_EN, tie stall_count to 0 and omit its register; all other behaviour is identical.

Verification
REQ-030 SHALL cover: issue rd=3 regwrite; next cycle issue rs1=3, no wb -> stall=1, pending=8'h08; wb_rd=3 wb_data=8'hA5 -> same cycle stall=0, fwd_rs1=1, fwd_data=8'hA5; pending=0 after the edge.
REQ-031 SHALL cover: pending[5]=1, same edge issue rd=5 regwrite and wb_rd=5 -> stall=0, pending[5]=1 after the edge (set wins).
REQ-032 SHALL cover: wb_valid with wb_rd=6 while pending=0 -> wb_err=1 the next cycle, held until reset.
REQ-033 SHALL cover: rs2 hazard with no writeback held 15 cycles, STALL_MAX=15 -> deadlock=1 on the 15th edge; stall_count=15 with the macro, 0 without.
REQ-034 SHALL cover: pending=8'hFF, deadlock=1, then reset one cycle with a concurrent issue -> stall=0 during reset; afterwards pending=0, deadlock=0, stall_count=0.
REQ-035 SHALL cover: issue_valid=0 with issue_rs1 on a pending register -> stall=0, fwd_rs1=0.
